// File: rtl/yutorina_bus_arbiter.sv
// Round-robin bus arbiter and master mux for four bus masters.
// Owner holds until it releases; the idle bus parks on the last owner.
module yutorina_bus_arbiter #(
  parameter int NUM_MASTERS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   m_req_,
  input  logic [119:0] m_addr,
  input  logic [3:0]   m_as_,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_w_data,
  output logic [3:0]   m_grnt_,
  output logic [29:0]  s_addr,
  output logic         s_as_,
  output logic         s_rw,
  output logic [31:0]  s_w_data,
  output logic [1:0]   owner
);

  logic [1:0] next_owner;
  logic [1:0] cand;

  // Smallest offset from owner+1 wins; no hit leaves owner parked.
  always_comb begin
    next_owner = owner;
    cand       = owner;
    if (m_req_[owner]) begin
      for (int k = 3; k >= 1; k--) begin
        cand = owner + 2'(k);
        if (!m_req_[cand]) next_owner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) owner <= 2'd0;
    else     owner <= next_owner;
  end

  assign m_grnt_ = ~(4'b0001 << owner);

  always_comb begin
    s_addr   = m_addr[29:0];
    s_as_    = m_as_[0];
    s_rw     = m_rw[0];
    s_w_data = m_w_data[31:0];
    for (int n = 1; n < NUM_MASTERS; n++) begin
      if (owner == 2'(n)) begin
        s_addr   = m_addr[30*n +: 30];
        s_as_    = m_as_[n];
        s_rw     = m_rw[n];
        s_w_data = m_w_data[32*n +: 32];
      end
    end
  end

endmodule

// File: doc/yutorina_bus_arbiter.md
# yutorina_bus_arbiter

Round-robin bus arbiter and master multiplexer for the shared system bus. Up to four masters share the bus: CPU instruction port (i_*), CPU data port (d_*) and two auxiliary masters such as DMA or debug. Each master requests ownership with an active-low request, holds it for any number of transfers, and releases it. The arbiter grants one master at a time and steers that master's address, strobe, direction and write data onto the shared bus.

## Interface
- NUM_MASTERS, 4, number of masters; fixed at 4 (2-bit owner index); other values unsupported.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- m_req_  in  4  per-master bus request, active-low; bit n = master n (0=i-port, 1=d-port, 2/3=aux).
- m_addr  in  4x30  per-master word address (flattened, master n at [30n+29:30n]).
- m_as_  in  4  per-master address strobe, active-low.
- m_rw  in  4  per-master direction (1=read, 0=write).
- m_w_data  in  4x32  per-master write data (flattened, master n at [32n+31:32n]).
- m_grnt_  out  4  per-master grant, active-low, one-hot-low.
- s_addr  out  30  shared bus address.
- s_as_  out  1  shared bus address strobe, active-low.
- s_rw  out  1  shared bus direction.
- s_w_data  out  32  shared bus write data.
- owner  out  2  index of the current grant holder.

## Operation
- State: 2-bit register `owner`. m_grnt_ = ~(1 << owner), exactly one bit low at all times; the bus is never ungranted, and the idle bus parks on the last owner.
- Hold rule: while m_req_[owner]==0, owner is unchanged regardless of other requests. There is no preemption and no timeout.
- Release/select: when m_req_[owner]==1, the next owner is the first master with req_ low, searching owner+1, owner+2, owner+3 (mod 4), then owner itself. If no master requests, owner is unchanged (park).
- Priority rotates: the releasing master has lowest priority on the next decision, so no master starves while others each release.
- Mux (combinational from owner): s_addr = m_addr[owner], s_rw = m_rw[owner], s_w_data = m_w_data[owner].
- Strobe gating: s_as_ = m_as_[owner]. Strobes from non-owners are ignored; they must never reach s_as_.
- Master protocol (master responsibility):
  - assert req_;
  - wait for grnt_ low;
  - issue transfers;
  - deassert as_ no later than the cycle in which req_ is released.
- Behaviour for as_ low on the release cycle is undefined to the master, but the arbiter still switches owner on the following edge.
- m_req_ of a parked owner that is not requesting has no effect; re-requesting by the parked owner yields grant with zero added latency (grnt_ already low).

## Timing
- Reset (rst=1 at edge): owner=0, m_grnt_=4'b1110. The mux outputs then follow master 0's inputs combinationally.
- Reset mid-ownership: the grant returns to master 0 on the edge where rst=1, regardless of requests. rst has priority over all arbitration.
- Grant latency: a request while the bus is parked on an idle owner gets its grant 1 cycle later (edge after req_ low sampled).
- Handover: owner releases req_ in cycle t. The next owner is decided from m_req_ sampled at the edge ending t and drives grnt_ from cycle t+1. The new master may drive as_ in t+1 at the earliest, giving one bus cycle of handover.
- Simultaneous requests with owner releasing: round-robin order from owner+1 decides. Example: owner=1 releases while 0 and 3 request, so 3 wins.
- Owner releases and re-requests in the very next cycle while others wait: others win because the rotation starts at owner+1.
- No combinational path from m_req_ to m_grnt_. Mux outputs have a combinational path from m_* inputs only.

## Test plan
- Reset: rst=1 with m_req_=4'b0000 -> after edge m_grnt_=4'b1110, owner=0. Hold rst=1 for 3 cycles -> grant unchanged.
- Single request: park on 0, m_req_=4'b1101 -> next cycle m_grnt_=4'b1101, owner=1. Drive m_addr[1]=30'h0000_1234, m_as_[1]=0 -> s_addr=30'h0000_1234, s_as_=0.
- Hold and rotation: owner=1 holds 10 cycles while m_req_[0], m_req_[2] and m_req_[3] are low -> grant stays 1. Master 1 releases -> owner 2. Master 2 releases -> owner 3, then 0.
- Strobe isolation: owner=0 with m_as_=4'b0001 (masters 1-3 strobing) and m_as_[0]=1 -> s_as_=1, s_addr=m_addr[0].
- Park/re-request: owner=2 releases with no other requests -> owner stays 2, m_grnt_=4'b1011. Master 2 re-requests -> transfers proceed with no grant change.
- Reset mid-ownership: owner=3 holding with req_ low, rst pulsed 1 cycle -> owner=0 on that edge. With m_req_[3] still low and m_req_[0] high, owner becomes 3 one cycle after reset release.
